// File: rtl/servo_channel_mux.sv
// servo_channel_mux: registered N-to-1 selector for servo duty words.
// Channel changes take effect only on PWM period boundaries (period_end), so
// dout never changes mid-period. In auto mode, the selector rotates through all
// channels and stays on each one for DWELL period boundaries.
module servo_channel_mux #(
  parameter  int WIDTH    = 5,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 8,
  localparam int SW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SW-1:0]             sel,
  input  logic                      sel_valid,
  input  logic                      auto,
  input  logic                      period_end,
  output logic [WIDTH-1:0]          dout,
  output logic [SW-1:0]             cur_sel,
  output logic                      switch_pending,
  output logic                      switched,
  output logic                      sel_err
);

  localparam int            DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST    = SW'(CHANNELS - 1);

  typedef enum logic [1:0] {M_IDLE, M_PEND, A_SCAN} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     pend_q, pend_d;
  logic [SW-1:0]     cur_q, cur_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              switched_q, switched_d;
  logic              sel_err_q, sel_err_d;

  logic [WIDTH-1:0]  ch [CHANNELS];
  logic              sel_ok;
  logic              req;
  logic [DW-1:0]     dwell_base;

  // Unpack the flat input bus into one duty word per channel.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign ch[k] = din[k*WIDTH +: WIDTH];
  end

  assign sel_ok = ({1'b0, sel} < (SW+1)'(CHANNELS));

  // Next-state logic: mode handling, boundary-deferred switching, dout reload.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d    = state_q;
    pend_d     = pend_q;
    cur_d      = cur_q;
    dwell_d    = dwell_q;
    dout_d     = dout_q;
    switched_d = 1'b0;
    sel_err_d  = 1'b0;
    req        = 1'b0;
    dwell_base = '0;

    if (auto) begin
      // Entering scan starts from a fresh count; pending manual requests are dropped.
      dwell_base = (state_q == A_SCAN) ? dwell_q : '0;
      state_d    = A_SCAN;
      pend_d     = '0;
      dwell_d    = dwell_base;
      if (period_end) begin
        if (dwell_base == DWELL_LAST) begin
          dwell_d = '0;
          cur_d   = (cur_q == CH_LAST) ? '0 : cur_q + 1'b1;
        end else begin
          dwell_d = dwell_base + 1'b1;
        end
      end
    end else begin
      dwell_d   = '0;
      req       = sel_valid & sel_ok;
      sel_err_d = sel_valid & ~sel_ok;
      if (req) pend_d = sel;
      if (period_end && (req || state_q == M_PEND)) begin
        // A request arriving on the boundary edge is applied at that same edge.
        cur_d   = req ? sel : pend_q;
        state_d = M_IDLE;
      end else if (req) begin
        state_d = M_PEND;
      end else if (state_q == A_SCAN) begin
        state_d = M_IDLE;
      end
    end

    if (period_end) begin
      dout_d     = ch[cur_d];
      switched_d = (cur_d != cur_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q    <= M_IDLE;
      pend_q     <= '0;
      cur_q      <= '0;
      dwell_q    <= '0;
      dout_q     <= '0;
      switched_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      dwell_q    <= dwell_d;
      dout_q     <= dout_d;
      switched_q <= switched_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign dout           = dout_q;
  assign cur_sel        = cur_q;
  assign switch_pending = (state_q == M_PEND);
  assign switched       = switched_q;
  assign sel_err        = sel_err_q;

endmodule

// File: tb/tb_servo_channel_mux.sv
// Testbench for servo_channel_mux: directed test-plan scenarios plus random
// stimulus, checked by a scoreboard fed from a behavioural model.
module tb_servo_channel_mux;

  localparam int WIDTH    = 5;
  localparam int CHANNELS = 4;
  localparam int DWELL    = 3;
  localparam int SW       = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [SW-1:0]             sel;
  logic                      sel_valid;
  logic                      auto;
  logic                      period_end;
  logic [WIDTH-1:0]          dout;
  logic [SW-1:0]             cur_sel;
  logic                      switch_pending;
  logic                      switched;
  logic                      sel_err;

  logic [WIDTH-1:0] tb_ch [CHANNELS];
  assign din = {tb_ch[3], tb_ch[2], tb_ch[1], tb_ch[0]};

  servo_channel_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .sel_valid(sel_valid),
    .auto(auto), .period_end(period_end), .dout(dout), .cur_sel(cur_sel),
    .switch_pending(switch_pending), .switched(switched), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] dout;
    logic [SW-1:0]    cur;
    logic             pend;
    logic             sw;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: mode flag, list of requests since the last boundary,
  // and the count of boundaries seen since scan was entered.
  bit               m_auto;
  int               m_cur;
  int               m_pe;
  int               m_pend[$];
  logic [WIDTH-1:0] m_dout;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_auto = 1'b0;
    m_cur  = 0;
    m_pe   = 0;
    m_pend.delete();
    m_dout = '0;
  endtask

  // Drive one cycle of inputs, push the expected post-edge outputs, advance a cycle.
  task automatic tick(bit v, int s, bit a, bit p);
    exp_t e;
    int   nc;
    sel_valid  = v;
    sel        = s[SW-1:0];
    auto       = a;
    period_end = p;
    nc    = m_cur;
    e.err = 1'b0;
    if (a) begin
      if (!m_auto) begin
        m_auto = 1'b1;
        m_pe   = 0;
        m_pend.delete();
      end
      if (p) begin
        m_pe++;
        if (m_pe % DWELL == 0) nc = (m_cur + 1) % CHANNELS;
      end
    end else begin
      m_auto = 1'b0;
      if (v) begin
        if (s < CHANNELS) m_pend.push_back(s);
        else e.err = 1'b1;
      end
      if (p && m_pend.size() > 0) begin
        nc = m_pend[$];
        m_pend.delete();
      end
    end
    if (p) m_dout = tb_ch[nc];
    e.sw   = (nc != m_cur);
    m_cur  = nc;
    e.dout = m_dout;
    e.cur  = SW'(m_cur);
    e.pend = (m_pend.size() > 0);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(string tag);
    sel_valid  = 1'b0;
    auto       = 1'b0;
    period_end = 1'b0;
    rst_n      = 1'b0;
    #1;
    check({tag, "_dout"},     32'(dout),           0);
    check({tag, "_cur_sel"},  32'(cur_sel),        0);
    check({tag, "_pending"},  32'(switch_pending), 0);
    check({tag, "_switched"}, 32'(switched),       0);
    check({tag, "_sel_err"},  32'(sel_err),        0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: each cycle, compare DUT outputs against the oldest expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("dout",           32'(dout),           32'(mon_e.dout));
      check("cur_sel",        32'(cur_sel),        32'(mon_e.cur));
      check("switch_pending", 32'(switch_pending), 32'(mon_e.pend));
      check("switched",       32'(switched),       32'(mon_e.sw));
      check("sel_err",        32'(sel_err),        32'(mon_e.err));
    end
  end

  logic [WIDTH-1:0] scan_seq [7];

  initial begin
    tb_ch[0] = 5'd3;  tb_ch[1] = 5'd8;  tb_ch[2] = 5'd16; tb_ch[3] = 5'd24;
    sel_valid = 1'b0; sel = '0; auto = 1'b0; period_end = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    do_reset("init_reset");

    // First boundary after reset loads channel 0.
    tick(0, 0, 0, 1);
    check("first_pe_dout", 32'(dout), 3);
    check("first_pe_switched", 32'(switched), 0);

    // Manual request waits for the boundary.
    tick(1, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("wait_pending", 32'(switch_pending), 1);
      check("wait_dout", 32'(dout), 3);
      tick(0, 0, 0, 0);
    end
    tick(0, 0, 0, 1);
    check("sw2_cur", 32'(cur_sel), 2);
    check("sw2_dout", 32'(dout), 16);
    check("sw2_pulse", 32'(switched), 1);
    tick(0, 0, 0, 0);
    check("sw2_pulse_end", 32'(switched), 0);

    // Last request wins, and the word is sampled at the boundary.
    tick(1, 1, 0, 0);
    tick(1, 3, 0, 0);
    tb_ch[3] = 5'd30;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    check("sw3_cur", 32'(cur_sel), 3);
    check("sw3_dout", 32'(dout), 30);
    tick(1, 3, 0, 1);
    check("same_sel_no_pulse", 32'(switched), 0);
    tb_ch[3] = 5'd24;

    // Auto scan from channel 3 with SEL_VALID noise between boundaries.
    scan_seq[0] = 5'd24; scan_seq[1] = 5'd24; scan_seq[2] = 5'd3; scan_seq[3] = 5'd3;
    scan_seq[4] = 5'd3;  scan_seq[5] = 5'd8;  scan_seq[6] = 5'd8;
    tick(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      tick(0, 0, 1, 1);
      check("scan_dout", 32'(dout), 32'(scan_seq[i]));
      tick(1, (i + 1) % CHANNELS, 1, 0);
    end
    check("scan_cur", 32'(cur_sel), 1);

    // Reset with dwell count at 2.
    tick(0, 0, 1, 1);
    do_reset("scan_reset");
    tick(0, 0, 0, 1);
    check("post_reset_dout", 32'(dout), 3);

    // Reset with a manual request pending.
    tick(1, 2, 0, 0);
    do_reset("pend_reset");
    tick(0, 0, 0, 1);
    check("pend_reset_cur", 32'(cur_sel), 0);
    check("pend_reset_dout", 32'(dout), 3);

    // Random stimulus against the model.
    begin
      bit a_lvl;
      a_lvl = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 19) == 0) a_lvl = ~a_lvl;
        if ($urandom_range(0, 9) == 0)
          tb_ch[$urandom_range(0, CHANNELS-1)] = WIDTH'($urandom);
        tick($urandom_range(0, 3) == 0, $urandom_range(0, CHANNELS-1),
             a_lvl, $urandom_range(0, 2) == 0);
      end
    end

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
